// File: rtl/dotl_pkg.sv
// ---------------------------------------------------------------------------
// dotl_pkg
// Shared definitions for the dotl display sink:
//   - 7-segment codes, bit order {g,f,e,d,c,b,a}, active-high
//   - traffic-light patterns, bit order {red, amber, green}
//   - display FSM state encoding
//   - helpers: dice value -> segments, pattern legality, legal successor
// ---------------------------------------------------------------------------
package dotl_pkg;

    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [2:0] TL_RED       = 3'b100;
    localparam logic [2:0] TL_RED_AMBER = 3'b110;
    localparam logic [2:0] TL_GREEN     = 3'b001;
    localparam logic [2:0] TL_AMBER     = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ROLLING  = 3'd1,
        ST_SETTLING = 3'd2,
        ST_SHOW     = 3'd3,
        ST_DFAULT   = 3'd4,
        ST_TRAFFIC  = 3'd5
    } state_t;

    // A dice value is only meaningful in the range 1..6.
    function automatic logic dice_valid(input logic [2:0] value);
        return (value != 3'd0) && (value != 3'd7);
    endfunction

    // Segment pattern for a dice value; out-of-range values show E.
    function automatic logic [6:0] dice_seg(input logic [2:0] value);
        logic [6:0] code;
        case (value)
            3'd1:    code = SEG_1;
            3'd2:    code = SEG_2;
            3'd3:    code = SEG_3;
            3'd4:    code = SEG_4;
            3'd5:    code = SEG_5;
            3'd6:    code = SEG_6;
            default: code = SEG_E;
        endcase
        return code;
    endfunction

    // True for the four patterns a well-behaved light sequence may show.
    function automatic logic tl_legal(input logic [2:0] pat);
        return (pat == TL_RED) || (pat == TL_RED_AMBER) ||
               (pat == TL_GREEN) || (pat == TL_AMBER);
    endfunction

    // Successor of a legal pattern in the red -> red/amber -> green -> amber
    // cycle. Illegal inputs map to red; callers screen them with tl_legal.
    function automatic logic [2:0] next_legal(input logic [2:0] pat);
        logic [2:0] nxt;
        case (pat)
            TL_RED:       nxt = TL_RED_AMBER;
            TL_RED_AMBER: nxt = TL_GREEN;
            TL_GREEN:     nxt = TL_AMBER;
            TL_AMBER:     nxt = TL_RED;
            default:      nxt = TL_RED;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/dotl_display_blinker.sv
// ---------------------------------------------------------------------------
// dotl_blinker
// Blink timebase shared by the dice fault and traffic fault displays.
// A counter runs 0..BLINK_DIV-1 while enabled; on wrap the phase toggles.
//   clk     : system clock, rising edge
//   rst     : synchronous, active-low reset (counter and phase to 0)
//   clear   : restart the timebase (counter 0, phase 0); wins over enable
//   enable  : advance the counter this cycle
//   phase   : current blink phase (0 = "on" half-period)
//   wrap    : counter sits at its last value, so the phase toggles on the
//             next enabled edge
// Both outputs come straight from flops, so the parent can predict the next
// phase as phase ^ wrap without a combinational path back through enable.
// ---------------------------------------------------------------------------
module dotl_blinker #(
    parameter int BLINK_DIV = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic phase,
    output logic wrap
);

    localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;

    // Next-state for the counter/phase pair; clear restarts the first
    // half-period so a fresh fault always begins in the "on" phase.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (clear) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (enable) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Timebase registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;
    assign wrap  = (cnt_q == CNT_LAST);

endmodule

// File: rtl/dotl_display.sv
// ---------------------------------------------------------------------------
// dotl_display
// Sink-side companion to dotl. Shows the 3-bit result either as a dice digit
// on a 7-segment display (sel=0) or on red/amber/green lamps (sel=1), and
// flags protocol violations (illegal dice value, illegal light pattern or
// illegal light transition) with a blinking E / amber lamp.
//   clk     : system clock, rising edge
//   rst     : synchronous, active-low reset
//   sel     : 0 = dice, 1 = traffic lights
//   button  : roll button (same signal that drives dotl)
//   result  : dice value 1..6 or light pattern {red, amber, green}
//   seg     : segments {g,f,e,d,c,b,a}, active-high
//   led_r/a/g : traffic lamps
//   settled : one-cycle pulse when a dice value is latched and shown
//   fault   : protocol violation flag
// All outputs are registered.
// ---------------------------------------------------------------------------
module dotl_display
    import dotl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int BLINK_DIV     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel,
    input  logic       button,
    input  logic [2:0] result,
    output logic [6:0] seg,
    output logic       led_r,
    output logic       led_a,
    output logic       led_g,
    output logic       settled,
    output logic       fault
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

    state_t        state_q, state_d;
    logic          sel_prev_q, sel_prev_d;
    logic [6:0]    seg_q, seg_d;
    logic          led_r_q, led_r_d;
    logic          led_a_q, led_a_d;
    logic          led_g_q, led_g_d;
    logic          settled_q, settled_d;
    logic          fault_q, fault_d;
    logic [SW-1:0] settle_cnt_q, settle_cnt_d;
    logic [2:0]    prev_pat_q, prev_pat_d;
    logic          prev_valid_q, prev_valid_d;

    logic          blink_clear;
    logic          blink_enable;
    logic          blink_phase;
    logic          blink_wrap;
    logic          blink_on_next;
    logic          traffic_ok;

    dotl_blinker #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blinker (
        .clk    (clk),
        .rst    (rst),
        .clear  (blink_clear),
        .enable (blink_enable),
        .phase  (blink_phase),
        .wrap   (blink_wrap)
    );

    // Phase the blinker will hold after this edge while it keeps running;
    // the "on" half (E shown, amber lit) is phase 0.
    assign blink_on_next = ~(blink_phase ^ blink_wrap);

    // A traffic sample is acceptable if the pattern itself is legal and it
    // either holds or advances the previous pattern; the first sample after
    // entry has no history and only needs to be a legal pattern.
    assign traffic_ok = tl_legal(result) &&
                        (!prev_valid_q ||
                         (result == prev_pat_q) ||
                         (result == next_legal(prev_pat_q)));

    // Next-state and next-output logic. A change of sel overrides every
    // state; within a mode the button (dice) or the sampled pattern
    // (traffic) drives the transitions.
    always_comb begin
        state_d      = state_q;
        sel_prev_d   = sel;
        seg_d        = seg_q;
        led_r_d      = led_r_q;
        led_a_d      = led_a_q;
        led_g_d      = led_g_q;
        settled_d    = 1'b0;
        fault_d      = fault_q;
        settle_cnt_d = settle_cnt_q;
        prev_pat_d   = prev_pat_q;
        prev_valid_d = prev_valid_q;
        blink_clear  = 1'b0;
        blink_enable = 1'b0;

        if (sel != sel_prev_q) begin
            state_d      = ST_IDLE;
            fault_d      = 1'b0;
            led_r_d      = 1'b0;
            led_a_d      = 1'b0;
            led_g_d      = 1'b0;
            seg_d        = SEG_BLANK;
            prev_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sel) begin
                        state_d = ST_TRAFFIC;
                        seg_d   = SEG_BLANK;
                        led_r_d = 1'b0;
                        led_a_d = 1'b0;
                        led_g_d = 1'b0;
                    end else if (button) begin
                        state_d = ST_ROLLING;
                        seg_d   = SEG_DASH;
                    end
                end

                ST_ROLLING: begin
                    seg_d = SEG_DASH;
                    if (!button) begin
                        state_d      = ST_SETTLING;
                        settle_cnt_d = SETTLE_LOAD;
                    end
                end

                ST_SETTLING: begin
                    seg_d = SEG_DASH;
                    if (button) begin
                        state_d = ST_ROLLING;
                    end else if (settle_cnt_q == '0) begin
                        if (dice_valid(result)) begin
                            state_d   = ST_SHOW;
                            seg_d     = dice_seg(result);
                            settled_d = 1'b1;
                        end else begin
                            state_d     = ST_DFAULT;
                            fault_d     = 1'b1;
                            seg_d       = SEG_E;
                            blink_clear = 1'b1;
                        end
                    end else begin
                        settle_cnt_d = settle_cnt_q - SW'(1);
                    end
                end

                ST_SHOW: begin
                    if (button) begin
                        state_d = ST_ROLLING;
                        seg_d   = SEG_DASH;
                    end
                end

                ST_DFAULT: begin
                    if (button) begin
                        state_d = ST_ROLLING;
                        fault_d = 1'b0;
                        seg_d   = SEG_DASH;
                    end else begin
                        blink_enable = 1'b1;
                        seg_d        = blink_on_next ? SEG_E : SEG_BLANK;
                    end
                end

                ST_TRAFFIC: begin
                    if (fault_q) begin
                        // Sticky fault: input patterns are ignored.
                        blink_enable = 1'b1;
                        led_r_d      = 1'b0;
                        led_g_d      = 1'b0;
                        led_a_d      = blink_on_next;
                        seg_d        = blink_on_next ? SEG_E : SEG_BLANK;
                    end else if (traffic_ok) begin
                        led_r_d      = result[2];
                        led_a_d      = result[1];
                        led_g_d      = result[0];
                        seg_d        = SEG_BLANK;
                        prev_pat_d   = result;
                        prev_valid_d = 1'b1;
                    end else begin
                        fault_d     = 1'b1;
                        led_r_d     = 1'b0;
                        led_a_d     = 1'b1;
                        led_g_d     = 1'b0;
                        seg_d       = SEG_E;
                        blink_clear = 1'b1;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Single state/output register bank; reset wins over everything.
    // sel_prev follows sel even in reset so the first edge after reset
    // does not look like a mode change.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            sel_prev_q   <= sel_prev_d;
            seg_q        <= SEG_BLANK;
            led_r_q      <= 1'b0;
            led_a_q      <= 1'b0;
            led_g_q      <= 1'b0;
            settled_q    <= 1'b0;
            fault_q      <= 1'b0;
            settle_cnt_q <= '0;
            prev_pat_q   <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_prev_q   <= sel_prev_d;
            seg_q        <= seg_d;
            led_r_q      <= led_r_d;
            led_a_q      <= led_a_d;
            led_g_q      <= led_g_d;
            settled_q    <= settled_d;
            fault_q      <= fault_d;
            settle_cnt_q <= settle_cnt_d;
            prev_pat_q   <= prev_pat_d;
            prev_valid_q <= prev_valid_d;
        end
    end

    assign seg     = seg_q;
    assign led_r   = led_r_q;
    assign led_a   = led_a_q;
    assign led_g   = led_g_q;
    assign settled = settled_q;
    assign fault   = fault_q;

endmodule

// File: tb/tb_dotl_display.sv
// ---------------------------------------------------------------------------
// tb_dotl_display
// Self-checking bench for dotl_display. Every clock edge is mirrored by a
// behavioural model that reasons in terms of "edges since release", "age of
// the fault" and position in the light cycle; outputs are compared #1 after
// each rising edge.
// ---------------------------------------------------------------------------
module tb_dotl_display;

    localparam int SETTLE = 4;
    localparam int BLINK  = 8;

    localparam logic [6:0] E_CODE    = 7'b1111001;
    localparam logic [6:0] DASH_CODE = 7'b1000000;

    logic       clk;
    logic       rst;
    logic       sel;
    logic       button;
    logic [2:0] result;
    logic [6:0] seg;
    logic       led_r, led_a, led_g;
    logic       settled;
    logic       fault;

    int errors = 0;
    int checks = 0;

    // Model state
    logic [6:0] seg_table [0:7];
    logic [2:0] order [0:3];
    logic       m_sel_prev;
    bit         m_roll;
    int         m_since;
    bit         m_dfault;
    int         m_age;
    bit         m_tr_entered;
    bit         m_tfault;
    int         m_prev_idx;

    // Expected outputs
    logic [6:0] e_seg;
    logic       e_r, e_a, e_g, e_settled, e_fault;

    dotl_display #(
        .SETTLE_CYCLES (SETTLE),
        .BLINK_DIV     (BLINK)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sel     (sel),
        .button  (button),
        .result  (result),
        .seg     (seg),
        .led_r   (led_r),
        .led_a   (led_a),
        .led_g   (led_g),
        .settled (settled),
        .fault   (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Position of a pattern in the red -> red/amber -> green -> amber cycle,
    // or -1 for a pattern that never belongs in it.
    function automatic int pat_index(input logic [2:0] p);
        for (int k = 0; k < 4; k++) begin
            if (order[k] == p) return k;
        end
        return -1;
    endfunction

    task automatic forget_mode();
        m_roll       = 0;
        m_since      = -1;
        m_dfault     = 0;
        m_age        = 0;
        m_tr_entered = 0;
        m_tfault     = 0;
        m_prev_idx   = -1;
    endtask

    // One clock edge of the reference model, given the inputs at that edge.
    task automatic model_edge(input logic r, input logic s, input logic b,
                              input logic [2:0] res);
        int  idx;
        bit  on;
        e_settled = 1'b0;
        if (!r) begin
            e_seg = 7'b0; e_r = 0; e_a = 0; e_g = 0; e_fault = 0;
            forget_mode();
            m_sel_prev = s;
        end else if (s != m_sel_prev) begin
            m_sel_prev = s;
            e_seg = 7'b0; e_r = 0; e_a = 0; e_g = 0; e_fault = 0;
            forget_mode();
        end else if (!s) begin
            e_r = 0; e_a = 0; e_g = 0;
            if (b) begin
                m_roll = 1; m_since = -1; m_dfault = 0;
                e_fault = 0; e_seg = DASH_CODE;
            end else if (m_roll) begin
                m_since++;
                if (m_since == SETTLE) begin
                    m_roll = 0;
                    if (res >= 3'd1 && res <= 3'd6) begin
                        e_seg = seg_table[res];
                        e_settled = 1'b1;
                    end else begin
                        m_dfault = 1; m_age = 0;
                        e_fault = 1; e_seg = E_CODE;
                    end
                end else begin
                    e_seg = DASH_CODE;
                end
            end else if (m_dfault) begin
                m_age++;
                e_seg = (((m_age / BLINK) % 2) == 0) ? E_CODE : 7'b0;
            end
        end else begin
            if (!m_tr_entered) begin
                m_tr_entered = 1;
                e_seg = 7'b0; e_r = 0; e_a = 0; e_g = 0;
            end else if (m_tfault) begin
                m_age++;
                on = (((m_age / BLINK) % 2) == 0);
                e_r = 0; e_g = 0; e_a = on;
                e_seg = on ? E_CODE : 7'b0;
            end else begin
                idx = pat_index(res);
                if (idx >= 0 && (m_prev_idx < 0 || idx == m_prev_idx ||
                                 idx == (m_prev_idx + 1) % 4)) begin
                    {e_r, e_a, e_g} = res;
                    m_prev_idx = idx;
                    e_seg = 7'b0;
                end else begin
                    m_tfault = 1; m_age = 0;
                    e_fault = 1; e_r = 0; e_a = 1; e_g = 0;
                    e_seg = E_CODE;
                end
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [11:0] obs;
        logic [11:0] exp;
        obs = {seg, led_r, led_a, led_g, settled, fault};
        exp = {e_seg, e_r, e_a, e_g, e_settled, e_fault};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: {seg,r,a,g,settled,fault} got %b expected %b (t=%0t)",
                   tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model with the same edge and
    // compare shortly after the edge.
    task automatic applyStimulus(input logic r, input logic s, input logic b,
                                 input logic [2:0] res, input string tag);
        rst = r; sel = s; button = b; result = res;
        @(posedge clk);
        model_edge(r, s, b, res);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        logic       rs, ss, bs;
        logic [2:0] vs;
        int         walk;
        logic [2:0] legal_seq [0:5];

        seg_table[0] = 7'b0;        seg_table[1] = 7'b0000110;
        seg_table[2] = 7'b1011011;  seg_table[3] = 7'b1001111;
        seg_table[4] = 7'b1100110;  seg_table[5] = 7'b1101101;
        seg_table[6] = 7'b1111101;  seg_table[7] = 7'b0;
        order[0] = 3'b100; order[1] = 3'b110; order[2] = 3'b001; order[3] = 3'b010;
        legal_seq[0] = 3'b100; legal_seq[1] = 3'b100; legal_seq[2] = 3'b110;
        legal_seq[3] = 3'b001; legal_seq[4] = 3'b010; legal_seq[5] = 3'b100;
        forget_mode();
        m_sel_prev = 1'b0;
        e_seg = 7'b0; e_r = 0; e_a = 0; e_g = 0; e_settled = 0; e_fault = 0;

        // Reset with random inputs
        for (int i = 0; i < 2; i++)
            applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)),
                          3'($urandom_range(0, 7)), "reset");

        // Dice roll of 3: dash while held, digit and single pulse after settle
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 1, 3'd3, "dice_rolling");
        for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 3'd3, "dice_settle3");

        // Re-press during settling: no latch, stays dash
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 3'd5, "repress_hold");
        for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, 3'd5, "repress_gap");
        for (int i = 0; i < 2; i++) applyStimulus(1, 0, 1, 3'd5, "repress_again");
        for (int i = 0; i < 7; i++) applyStimulus(1, 0, 0, 3'd5, "repress_settle");

        // Invalid value 7 at latch: blinking E, cleared by the next press
        for (int i = 0; i < 2; i++)  applyStimulus(1, 0, 1, 3'd7, "invalid_hold");
        for (int i = 0; i < 40; i++) applyStimulus(1, 0, 0, 3'd7, "invalid_blink");
        applyStimulus(1, 0, 1, 3'd2, "invalid_clear");
        applyStimulus(1, 0, 0, 3'd2, "invalid_release");

        // Random dice rolls including out-of-range values
        for (int k = 0; k < 8; k++) begin
            vs = 3'($urandom_range(0, 7));
            for (int i = 0; i < int'($urandom_range(1, 4)); i++)
                applyStimulus(1, 0, 1, 3'($urandom_range(0, 7)), "rand_roll_hold");
            for (int i = 0; i < SETTLE + 3 + int'($urandom_range(0, 10)); i++)
                applyStimulus(1, 0, 0, vs, "rand_roll_settle");
        end

        // Traffic legal sequence (mode change, entry, then samples)
        applyStimulus(1, 1, 0, 3'b100, "tl_mode_change");
        applyStimulus(1, 1, 0, 3'b100, "tl_entry");
        for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, legal_seq[i], "tl_legal");

        // Illegal transition 100 -> 001, then ignored inputs while blinking
        applyStimulus(1, 1, 0, 3'b001, "tl_bad_transition");
        for (int i = 0; i < 20; i++)
            applyStimulus(1, 1, 0, 3'($urandom_range(0, 7)), "tl_fault_blink");

        // sel back to 0 clears the fault on the next edge
        applyStimulus(1, 0, 0, 3'b100, "tl_sel_clear");
        applyStimulus(1, 0, 0, 3'b100, "tl_sel_idle");

        // Illegal pattern 111 from a clean traffic state
        applyStimulus(1, 1, 0, 3'b100, "tl2_mode_change");
        applyStimulus(1, 1, 0, 3'b100, "tl2_entry");
        applyStimulus(1, 1, 0, 3'b111, "tl_pattern_111");
        for (int i = 0; i < 11; i++) applyStimulus(1, 1, 0, 3'b100, "tl2_blink");

        // Reset mid-blink
        applyStimulus(0, 1, 1, 3'b010, "reset_mid_blink");
        applyStimulus(1, 1, 0, 3'b010, "post_reset_entry");
        applyStimulus(1, 1, 0, 3'b010, "post_reset_sample");

        // Randomised mixed traffic: mostly legal walks with occasional noise
        rs = 1; ss = 1; bs = 0; walk = 3;
        for (int i = 0; i < 600; i++) begin
            rs = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 99) < 3)  ss = ~ss;
            if ($urandom_range(0, 99) < 15) bs = ~bs;
            if (ss) begin
                if ($urandom_range(0, 99) < 40) walk = (walk + 1) % 4;
                vs = ($urandom_range(0, 99) < 5) ? 3'($urandom_range(0, 7)) : order[walk];
            end else begin
                vs = 3'($urandom_range(0, 7));
            end
            applyStimulus(rs, ss, bs, vs, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
